// File: rtl/antilog_decoder_if.sv
// rtl/antilog_decoder_if.sv - input/output handshake bundle of the antilog decoder
interface antilog_decoder_if #(
  parameter int K_W    = 4,
  parameter int FRAC_W = 7,
  parameter int OUT_W  = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [K_W-1:0]    in_k;
  logic [FRAC_W-1:0] in_frac;
  logic              in_zero;
  logic              out_valid;
  logic              out_ready;
  logic [OUT_W-1:0]  out_data;
  logic              out_ovf;

  modport master (
    output in_valid, in_k, in_frac, in_zero, out_ready,
    input  in_ready, out_valid, out_data, out_ovf
  );

  modport slave (
    input  in_valid, in_k, in_frac, in_zero, out_ready,
    output in_ready, out_valid, out_data, out_ovf
  );
endinterface

// File: rtl/antilog_decoder.sv
// rtl/antilog_decoder.sv - two-stage pipelined antilog converter, (1.f)*2^k with saturation and optional rounding
module antilog_decoder #(
  parameter int IN_W   = 8,
  parameter int K_W    = 4,
  parameter int FRAC_W = 7,
  parameter int OUT_W  = 16,
  parameter int ROUND  = 1
) (
  input logic              clk,
  input logic              rst_n,
  antilog_decoder_if.slave bus
);
  localparam int KMAX   = 2*IN_W - 2;
  localparam int FULL_W = FRAC_W + OUT_W;
  localparam bit DO_ROUND = (ROUND != 0) && (FRAC_W > 0);
  // Keep the first discarded bit in the window when rounding.
  localparam int SHR    = DO_ROUND ? FRAC_W - 1 : FRAC_W;
  localparam int WIN_W  = DO_ROUND ? OUT_W + 1 : OUT_W;
  localparam logic [K_W-1:0] KMAX_K = K_W'(KMAX);

  logic              s1_valid;
  logic [FRAC_W:0]   s1_mant;
  logic [K_W-1:0]    s1_k;
  logic              s1_zero;
  logic              s1_ovf;

  logic              s2_valid;
  logic [OUT_W-1:0]  s2_data;
  logic              s2_ovf;

  logic              s1_adv;
  logic              s2_adv;
  logic [WIN_W-1:0]  win;
  logic [OUT_W-1:0]  res;
  logic [OUT_W-1:0]  s2_data_d;

  assign s2_adv       = ~s2_valid | bus.out_ready;
  assign s1_adv       = ~s1_valid | s2_adv;
  assign bus.in_ready = s1_adv;

  assign win = WIN_W'((FULL_W'(s1_mant) << s1_k) >> SHR);

  generate
    if (DO_ROUND) begin : g_round
      assign res = win[WIN_W-1:1] + {{(OUT_W-1){1'b0}}, win[0]};
    end else begin : g_trunc
      assign res = win;
    end
  endgenerate

  always_comb begin
    s2_data_d = res;
    if (s1_zero) begin
      s2_data_d = '0;
    end else if (s1_ovf) begin
      s2_data_d = '1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_mant  <= '0;
      s1_k     <= '0;
      s1_zero  <= 1'b0;
      s1_ovf   <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_mant <= {1'b1, bus.in_frac};
        s1_k    <= bus.in_k;
        s1_zero <= bus.in_zero;
        s1_ovf  <= (bus.in_k > KMAX_K) & ~bus.in_zero;
      end
    end
  end

  // Output register holds its last word across bubbles and stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_data  <= '0;
      s2_ovf   <= 1'b0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_data <= s2_data_d;
        s2_ovf  <= s1_ovf;
      end
    end
  end

  assign bus.out_valid = s2_valid;
  assign bus.out_data  = s2_data;
  assign bus.out_ovf   = s2_ovf;
endmodule
